link_tx_ctrl: RTL and testbench

- Downstream neighbour of the per-port output VC stage.
- Pops flits from the output stage's arbitrated read side (read enable, empty flag, 64-bit data) and drives them onto the inter-router link.
- Enforces credit-based flow control against the 32-slot VC buffer of the next router, so no flit is ever sent without a reserved downstream slot.
- Provides link enable/drain control, a credit-overflow error flag and a sent-flit counter.

---
 rtl/link_tx_ctrl.sv | 85 ++++++++
 tb/tb_link_tx_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/link_tx_ctrl.sv
// Link transmit controller: pops flits from the output VC stage and drives them
// onto the inter-router link under credit-based flow control.
module link_tx_ctrl #(
  parameter int DATA_W  = 64,
  parameter int CREDITS = 32,
  parameter int CNT_W   = 6,
  parameter int SENT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_en,
  input  logic              src_empty,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_read_en,
  input  logic              credit_in,
  output logic              link_valid,
  output logic [DATA_W-1:0] link_data,
  output logic [CNT_W-1:0]  credit_count,
  output logic              busy,
  output logic              credit_err,
  output logic [SENT_W-1:0] sent_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_t state, state_nxt;
  logic   pend;
  logic   pop;

  // A pop reserves a downstream slot, so it is gated on a non-zero count.
  assign pop         = (state == ACTIVE) && link_en && !src_empty && (credit_count != '0);
  assign src_read_en = pop;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (link_en) state_nxt = ACTIVE;
      ACTIVE:  if (!link_en) state_nxt = DRAIN;
      // With pend clear the last in-flight flit is on the link this cycle.
      DRAIN:   if (!pend) state_nxt = link_en ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= 1'b0;
      link_valid <= 1'b0;
      link_data  <= '0;
      sent_count <= '0;
    end else begin
      pend       <= pop;
      link_valid <= pend;
      if (pend) begin
        link_data  <= src_data;
        sent_count <= sent_count + SENT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_count <= CRED_MAX;
      credit_err   <= 1'b0;
    end else begin
      case ({pop, credit_in})
        2'b10: credit_count <= credit_count - CNT_W'(1);
        2'b01: begin
          if (credit_count == CRED_MAX) credit_err   <= 1'b1;
          else                          credit_count <= credit_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_link_tx_ctrl.sv
// Directed self-checking bench for link_tx_ctrl; inputs change and outputs are
// sampled around the falling clock edge.
module tb_link_tx_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        link_en;
  logic        src_empty;
  logic [63:0] src_data;
  logic        src_read_en;
  logic        credit_in;
  logic        link_valid;
  logic [63:0] link_data;
  logic [5:0]  credit_count;
  logic        busy;
  logic        credit_err;
  logic [15:0] sent_count;

  int n_cmp = 0;
  int n_bad = 0;

  link_tx_ctrl dut (
    .clk(clk), .reset(reset), .link_en(link_en), .src_empty(src_empty),
    .src_data(src_data), .src_read_en(src_read_en), .credit_in(credit_in),
    .link_valid(link_valid), .link_data(link_data), .credit_count(credit_count),
    .busy(busy), .credit_err(credit_err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; link_en = 1'b0; src_empty = 1'b1; credit_in = 1'b0; src_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (credit_count !== 6'd32) begin n_bad++; $display("FAIL reset_credit: got %0d want 32", credit_count); end
    n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", link_valid); end
    n_cmp++; if (link_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", link_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", credit_err); end
    n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL reset_sent: got %0d want 0", sent_count); end
  endtask

  task automatic test_single_pop();
    apply_reset();
    link_en = 1'b1;                      // IDLE -> ACTIVE at next edge
    @(negedge clk);
    src_empty = 1'b0; src_data = 64'hDEADBEEF_00000001; #1;
    n_cmp++; if (src_read_en !== 1'b1) begin n_bad++; $display("FAIL single_pop_t: got %0b want 1", src_read_en); end
    @(negedge clk);
    src_empty = 1'b1; #1;
    n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_t1: got %0b want 0", link_valid); end
    n_cmp++; if (credit_count !== 6'd31) begin n_bad++; $display("FAIL single_credit: got %0d want 31", credit_count); end
    @(negedge clk); #1;
    n_cmp++; if (link_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_t2: got %0b want 1", link_valid); end
    n_cmp++; if (link_data !== 64'hDEADBEEF_00000001) begin n_bad++; $display("FAIL single_data: got %h want deadbeef00000001", link_data); end
    n_cmp++; if (sent_count !== 16'd1) begin n_bad++; $display("FAIL single_sent: got %0d want 1", sent_count); end
    @(negedge clk); #1;
    n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_t3: got %0b want 0", link_valid); end
    n_cmp++; if (link_data !== 64'hDEADBEEF_00000001) begin n_bad++; $display("FAIL single_hold: got %h want deadbeef00000001", link_data); end
  endtask

  task automatic test_exhaust();
    int pops = 0;
    int vals = 0;
    apply_reset();
    link_en = 1'b1; src_empty = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      src_data = 64'(i); #1;
      if (src_read_en === 1'b1) pops++;
      if (link_valid === 1'b1) vals++;
    end
    n_cmp++; if (pops !== 32) begin n_bad++; $display("FAIL exhaust_pops: got %0d want 32", pops); end
    n_cmp++; if (vals !== 32) begin n_bad++; $display("FAIL exhaust_valids: got %0d want 32", vals); end
    n_cmp++; if (credit_count !== 6'd0) begin n_bad++; $display("FAIL exhaust_credit: got %0d want 0", credit_count); end
    n_cmp++; if (sent_count !== 16'd32) begin n_bad++; $display("FAIL exhaust_sent: got %0d want 32", sent_count); end
    n_cmp++; if (src_read_en !== 1'b0) begin n_bad++; $display("FAIL exhaust_gate: got %0b want 0", src_read_en); end
  endtask

  // Continues from the exhausted state: link_en=1, src_empty=0, count=0.
  task automatic test_credit_return();
    @(negedge clk);
    credit_in = 1'b1; #1;
    n_cmp++; if (src_read_en !== 1'b0) begin n_bad++; $display("FAIL cr_zero_gate: got %0b want 0", src_read_en); end
    @(negedge clk);
    credit_in = 1'b0; #1;
    n_cmp++; if (credit_count !== 6'd1) begin n_bad++; $display("FAIL cr_count1: got %0d want 1", credit_count); end
    n_cmp++; if (src_read_en !== 1'b1) begin n_bad++; $display("FAIL cr_pop: got %0b want 1", src_read_en); end
    @(negedge clk); #1;
    n_cmp++; if (credit_count !== 6'd0) begin n_bad++; $display("FAIL cr_back0: got %0d want 0", credit_count); end
    n_cmp++; if (src_read_en !== 1'b0) begin n_bad++; $display("FAIL cr_regate: got %0b want 0", src_read_en); end
    credit_in = 1'b1;
    @(negedge clk);                      // count=1, pop now active; return another credit
    #1;
    n_cmp++; if (src_read_en !== 1'b1) begin n_bad++; $display("FAIL cr_same_pop: got %0b want 1", src_read_en); end
    @(negedge clk);
    credit_in = 1'b0; #1;
    n_cmp++; if (credit_count !== 6'd1) begin n_bad++; $display("FAIL cr_same_cycle: got %0d want 1", credit_count); end
    @(negedge clk); #1;
    n_cmp++; if (credit_count !== 6'd0) begin n_bad++; $display("FAIL cr_final: got %0d want 0", credit_count); end
  endtask

  task automatic test_drain();
    int pops = 0;
    apply_reset();
    link_en = 1'b1; src_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      src_data = 64'h100 + 64'(i); #1;
      if (src_read_en === 1'b1) pops++;
    end
    @(negedge clk);
    link_en = 1'b0; #1;
    n_cmp++; if (src_read_en !== 1'b0) begin n_bad++; $display("FAIL drain_nopop: got %0b want 0", src_read_en); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy0: got %0b want 1", busy); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy1: got %0b want 1", busy); end
    n_cmp++; if (link_valid !== 1'b1) begin n_bad++; $display("FAIL drain_lastflit: got %0b want 1", link_valid); end
    n_cmp++; if (link_data !== 64'h105) begin n_bad++; $display("FAIL drain_lastdata: got %h want 105", link_data); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drain_idle: got %0b want 0", busy); end
    n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid_off: got %0b want 0", link_valid); end
    n_cmp++; if (sent_count !== 16'(pops)) begin n_bad++; $display("FAIL drain_sent: got %0d want %0d", sent_count, pops); end
    n_cmp++; if (credit_count !== 6'(32 - pops)) begin n_bad++; $display("FAIL drain_credit: got %0d want %0d", credit_count, 32 - pops); end
  endtask

  task automatic test_credit_err();
    apply_reset();
    @(negedge clk);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0; #1;
    n_cmp++; if (credit_count !== 6'd32) begin n_bad++; $display("FAIL err_count: got %0d want 32", credit_count); end
    n_cmp++; if (credit_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %0b want 1", credit_err); end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (credit_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", credit_err); end
    apply_reset();
    n_cmp++; if (credit_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0b want 0", credit_err); end
  endtask

  task automatic test_reset_mid();
    int vals = 0;
    apply_reset();
    link_en = 1'b1;
    @(negedge clk);
    src_empty = 1'b0; src_data = 64'hCAFE; #1;
    n_cmp++; if (src_read_en !== 1'b1) begin n_bad++; $display("FAIL mid_pop: got %0b want 1", src_read_en); end
    @(negedge clk);
    reset = 1'b1; link_en = 1'b0; src_empty = 1'b1; #1;
    n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %0b want 0", link_valid); end
    n_cmp++; if (credit_count !== 6'd32) begin n_bad++; $display("FAIL mid_credit: got %0d want 32", credit_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (link_valid === 1'b1) vals++;
    end
    n_cmp++; if (vals !== 0) begin n_bad++; $display("FAIL mid_noflit: got %0d want 0", vals); end
    n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL mid_sent: got %0d want 0", sent_count); end
  endtask

  initial begin
    reset = 1'b1; link_en = 1'b0; src_empty = 1'b1; credit_in = 1'b0; src_data = '0;
    test_reset();
    test_single_pop();
    test_exhaust();
    test_credit_return();
    test_drain();
    test_credit_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
